// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared state encoding and control-bundle layout for the backprop sequencer
package bp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        CALC,
        STORE,
        PROP,
        DONE,
        ABORT
    } bp_state_t;

    // Bit offsets of the single-bit fields in ctrl_bundle (LSB side)
    localparam int OFF_RESET = 0;
    localparam int OFF_CAL   = 1;
    localparam int OFF_PROP  = 2;
    localparam int OFF_STORE = 3;
    localparam int OFF_ROW   = 4;

    function automatic int bundle_w(input int idx_w);
        return 3 * idx_w + 4;
    endfunction

    function automatic int off_layer(input int idx_w);
        return OFF_ROW + idx_w;
    endfunction

    function automatic int off_current(input int idx_w);
        return OFF_ROW + 2 * idx_w;
    endfunction

endpackage

// File: rtl/bp_index_counter.sv
// rtl/bp_index_counter.sv - nested row/layer counter; rows count up and saturate, layers count down to 0
module bp_index_counter #(
    parameter int ROWS  = 3,
    parameter int IDX_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [IDX_W-1:0] load_layer,
    input  logic             step_row,
    input  logic             step_layer,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] layer,
    output logic             row_last,
    output logic             layer_zero
);

    assign row_last   = (row == IDX_W'(ROWS - 1));
    assign layer_zero = (layer == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row   <= '0;
            layer <= '0;
        end else if (load) begin
            row   <= '0;
            layer <= load_layer;
        end else if (step_layer) begin
            row <= '0;
            if (!layer_zero) begin
                layer <= layer - 1'b1;
            end
        end else if (step_row && !row_last) begin
            row <= row + 1'b1;
        end
    end

endmodule

// File: rtl/backprop_sequencer.sv
// rtl/backprop_sequencer.sv - walks layers last-to-first and rows 0..ROWS-1, issuing clear/calc/store/propagate strobes
module backprop_sequencer
    import bp_pkg::*;
#(
    parameter  int ROWS       = 3,
    parameter  int MAX_LAYERS = 4,
    parameter  int IDX_W      = 32,
    localparam int BUNDLE_W   = 3 * IDX_W + 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [IDX_W-1:0]    layer_count,
    input  logic                step_ready,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    current_layer_out,
    output logic [IDX_W-1:0]    dc_dw_layer_out,
    output logic [IDX_W-1:0]    dc_dw_row_out,
    output logic                update_storage_out,
    output logic                update_dy_dy_old_out,
    output logic                cal_dc_dw_out,
    output logic                cal_dc_dw_out_forward,
    output logic                reset_out,
    output logic [IDX_W-1:0]    weight_row,
    output logic [IDX_W-1:0]    weight_layer,
    output logic [BUNDLE_W-1:0] ctrl_bundle
);

    bp_state_t        state;
    bp_state_t        state_next;
    logic [IDX_W-1:0] layers_lat;
    logic [IDX_W-1:0] layers_clamped;
    logic             latch_en;
    logic             cnt_load;
    logic             cnt_step_row;
    logic             cnt_step_layer;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] layer;
    logic             row_last;
    logic             layer_zero;

    assign layers_clamped = (layer_count > IDX_W'(MAX_LAYERS)) ? IDX_W'(MAX_LAYERS) : layer_count;

    bp_index_counter #(
        .ROWS  (ROWS),
        .IDX_W (IDX_W)
    ) u_index (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_layer (layers_lat - 1'b1),
        .step_row   (cnt_step_row),
        .step_layer (cnt_step_layer),
        .row        (row),
        .layer      (layer),
        .row_last   (row_last),
        .layer_zero (layer_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            layers_lat <= '0;
        end else begin
            state <= state_next;
            if (latch_en) begin
                layers_lat <= layers_clamped;
            end
        end
    end

    // Abort outranks everything, including a same-cycle start in IDLE
    always_comb begin
        state_next     = state;
        latch_en       = 1'b0;
        cnt_load       = 1'b0;
        cnt_step_row   = 1'b0;
        cnt_step_layer = 1'b0;
        if (abort && state != IDLE) begin
            state_next = (state == ABORT) ? IDLE : ABORT;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (layers_clamped == '0) begin
                            state_next = DONE;
                        end else begin
                            latch_en   = 1'b1;
                            state_next = CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    cnt_load   = 1'b1;
                    state_next = CALC;
                end
                CALC: begin
                    if (step_ready) begin
                        if (row_last) begin
                            state_next = STORE;
                        end else begin
                            cnt_step_row = 1'b1;
                        end
                    end
                end
                STORE: begin
                    if (step_ready) begin
                        state_next = layer_zero ? DONE : PROP;
                    end
                end
                PROP: begin
                    if (step_ready) begin
                        cnt_step_layer = 1'b1;
                        state_next     = CALC;
                    end
                end
                DONE:    state_next = IDLE;
                ABORT:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy                  = (state != IDLE);
    assign done                  = (state == DONE);
    assign reset_out             = (state == CLEAR) || (state == ABORT);
    assign cal_dc_dw_out         = (state == CALC);
    assign cal_dc_dw_out_forward = cal_dc_dw_out;
    assign update_storage_out    = (state == STORE);
    assign update_dy_dy_old_out  = (state == PROP);
    assign current_layer_out     = layer;
    assign dc_dw_layer_out       = layer;
    assign dc_dw_row_out         = row;
    assign weight_row            = row;
    assign weight_layer          = layer;

    assign ctrl_bundle = {current_layer_out, dc_dw_layer_out, dc_dw_row_out,
                          update_storage_out, update_dy_dy_old_out, cal_dc_dw_out, reset_out};

endmodule

// File: tb/tb_backprop_sequencer.sv
// tb/tb_backprop_sequencer.sv - scoreboard bench: directed passes push expected cycles, a monitor pops and compares
module tb_backprop_sequencer;

    localparam int ROWS  = 3;
    localparam int IDX_W = 32;
    localparam int BW    = 3 * IDX_W + 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [IDX_W-1:0] layer_count;
    logic             step_ready;
    logic             busy, done;
    logic [IDX_W-1:0] current_layer_out, dc_dw_layer_out, dc_dw_row_out;
    logic             update_storage_out, update_dy_dy_old_out, cal_dc_dw_out;
    logic             cal_dc_dw_out_forward, reset_out;
    logic [IDX_W-1:0] weight_row, weight_layer;
    logic [BW-1:0]    ctrl_bundle;

    backprop_sequencer dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .start                 (start),
        .abort                 (abort),
        .layer_count           (layer_count),
        .step_ready            (step_ready),
        .busy                  (busy),
        .done                  (done),
        .current_layer_out     (current_layer_out),
        .dc_dw_layer_out       (dc_dw_layer_out),
        .dc_dw_row_out         (dc_dw_row_out),
        .update_storage_out    (update_storage_out),
        .update_dy_dy_old_out  (update_dy_dy_old_out),
        .cal_dc_dw_out         (cal_dc_dw_out),
        .cal_dc_dw_out_forward (cal_dc_dw_out_forward),
        .reset_out             (reset_out),
        .weight_row            (weight_row),
        .weight_layer          (weight_layer),
        .ctrl_bundle           (ctrl_bundle)
    );

    always #5 clk = ~clk;

    // stb = {store, prop, cal, reset}
    typedef struct {
        logic [3:0]  stb;
        logic        dn;
        logic        chk;
        logic [31:0] cur;
        logic [31:0] lay;
        logic [31:0] row;
    } exp_t;

    exp_t exp_q[$];
    int   len_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] stb, input logic dn, input logic c,
                        input int cur, input int lay, input int row);
        exp_t e;
        e.stb = stb; e.dn = dn; e.chk = c;
        e.cur = cur; e.lay = lay; e.row = row;
        exp_q.push_back(e);
    endtask

    // Expected cycle list for a clean pass of L layers; extra copies of cal(L-1,1) model a stall
    task automatic push_pass(input int L, input int hold_extra);
        if (L == 0) begin
            push(4'b0000, 1'b1, 1'b0, 0, 0, 0);
            len_q.push_back(1);
        end else begin
            push(4'b0001, 1'b0, 1'b0, 0, 0, 0);
            for (int l = L - 1; l >= 0; l--) begin
                for (int r = 0; r < ROWS; r++) begin
                    push(4'b0010, 1'b0, 1'b1, l, l, r);
                    if (l == L - 1 && r == 1)
                        for (int k = 0; k < hold_extra; k++) push(4'b0010, 1'b0, 1'b1, l, l, r);
                end
                push(4'b1000, 1'b0, 1'b1, l, l, ROWS - 1);
                if (l > 0) push(4'b0100, 1'b0, 1'b1, l, l, ROWS - 1);
            end
            push(4'b0000, 1'b1, 1'b1, 0, 0, ROWS - 1);
            len_q.push_back(1 + L * (ROWS + 1) + (L - 1) + 1 + hold_extra);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && (busy || done)) begin
            exp_t e;
            cyc++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {done, update_storage_out, update_dy_dy_old_out, cal_dc_dw_out, reset_out}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobes", {cal_dc_dw_out_forward, update_storage_out, update_dy_dy_old_out,
                                cal_dc_dw_out, reset_out, done},
                               {e.stb[1], e.stb, e.dn});
                if (e.chk) begin
                    chk("indices", {current_layer_out, dc_dw_layer_out, dc_dw_row_out, weight_layer, weight_row},
                                   {e.cur, e.lay, e.row, e.lay, e.row});
                    chk("bundle", ctrl_bundle, {e.cur, e.lay, e.row, e.stb});
                end else begin
                    chk("bundle_strobes", ctrl_bundle[3:0], e.stb);
                end
            end
            if (done) begin
                if (len_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("pass_length", cyc, len_q.pop_front());
                cyc = 0;
            end
        end else begin
            cyc = 0;
        end
    end

    task automatic run_pass(input int lc, input int stall_from, input int stall_len,
                            input int restart_at, input int abort_at);
        int c;
        layer_count = lc; start = 1'b1; step_ready = 1'b1; abort = 1'b0;
        tick();
        start = 1'b0;
        c = 1;
        while (busy && c < 200) begin
            step_ready = !(c >= stall_from && c < stall_from + stall_len);
            start      = (c == restart_at);
            abort      = (c == abort_at);
            tick();
            c++;
        end
        start = 1'b0; abort = 1'b0; step_ready = 1'b1;
        chk("idle_after_pass", {busy, done}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; step_ready = 1'b1; layer_count = '0;
        repeat (3) tick();
        chk("reset_state", {busy, done, ctrl_bundle}, 0);
        reset_n = 1'b1;
        tick();

        // Basic pass
        push_pass(2, 0);
        run_pass(2, 0, 0, 0, 0);
        // Stall at cal(1,1) for 5 cycles -> 16 cycles
        push_pass(2, 5);
        run_pass(2, 3, 5, 0, 0);
        // Zero layers
        push_pass(0, 0);
        run_pass(0, 0, 0, 0, 0);
        // Clamp 9 -> 4 layers, 21 cycles
        push_pass(4, 0);
        run_pass(9, 0, 0, 0, 0);

        // Abort during STORE of layer 1
        push(4'b0001, 1'b0, 1'b0, 0, 0, 0);
        for (int r = 0; r < ROWS; r++) push(4'b0010, 1'b0, 1'b1, 1, 1, r);
        push(4'b1000, 1'b0, 1'b1, 1, 1, ROWS - 1);
        push(4'b0001, 1'b0, 1'b0, 0, 0, 0);
        run_pass(2, 0, 0, 0, 5);
        push_pass(1, 0);
        run_pass(1, 0, 0, 0, 0);

        // Start and abort together in IDLE: nothing happens
        layer_count = 2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {busy, done, ctrl_bundle[3:0]}, 0);
        tick();
        chk("start_abort_idle2", {busy, done}, 0);

        // Async reset mid-CALC
        push(4'b0001, 1'b0, 1'b0, 0, 0, 0);
        push(4'b0010, 1'b0, 1'b1, 1, 1, 0);
        layer_count = 2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs", {busy, done, ctrl_bundle}, 0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_reset", {busy, done, ctrl_bundle}, 0);

        // Start pulsed during PROP is ignored: same 11-cycle pass
        push_pass(2, 0);
        run_pass(2, 0, 0, 6, 0);

        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("lengths_drained", len_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
